// File: rtl/sme_job_driver.sv
// Host-side job driver for the string-match engine: buffers one string/pattern job,
// streams it to the engine, and holds the engine's result for the host.
module sme_job_driver #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       send_string,
    input  logic       start,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_overrun,
    output logic       underrun
);
    localparam int unsigned SIW = $clog2(STR_MAX);
    localparam int unsigned PIW = $clog2(PAT_MAX);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND_STR, SEND_PAT, WAIT} state_t;

    state_t         state, state_nx;
    logic [SIW-1:0] idx, idx_nx;
    logic [7:0]     str_mem [STR_MAX];
    logic [7:0]     pat_mem [PAT_MAX];
    logic [5:0]     job_str_len;
    logic [3:0]     job_pat_len;
    logic           job_send_str;
    logic           armed;
    logic [TW-1:0]  wait_cnt;
    logic [7:0]     chardata_q;
    logic           isstring_q, ispattern_q;
    logic           latch_job, arm_set, armed_clr, capture, timeout_hit, underrun_set, launch_c;

    // Job buffers: plain storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            if (cfg_sel) pat_mem[cfg_addr[PIW-1:0]] <= cfg_data;
            else         str_mem[cfg_addr[SIW-1:0]] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        latch_job    = 1'b0;
        arm_set      = 1'b0;
        armed_clr    = 1'b0;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        underrun_set = 1'b0;
        launch_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_job = 1'b1;
                    state_nx  = send_string ? SEND_STR : SEND_PAT;
                    idx_nx    = '0;
                end
            end
            SEND_STR: begin
                if (6'(idx) == job_str_len - 6'd1) begin
                    state_nx = SEND_PAT;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + SIW'(1);
                end
            end
            SEND_PAT: begin
                if (6'(idx) == 6'(job_pat_len) - 6'd1) begin
                    state_nx = WAIT;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + SIW'(1);
                end
            end
            WAIT: begin
                if (sme_valid) begin
                    capture   = 1'b1;
                    armed_clr = 1'b1;
                    if (armed) begin
                        // First character of the armed job goes out in this very cycle.
                        launch_c = 1'b1;
                        if (job_send_str) begin
                            state_nx = (job_str_len == 6'd1) ? SEND_PAT : SEND_STR;
                            idx_nx   = (job_str_len == 6'd1) ? SIW'(0) : SIW'(1);
                        end else begin
                            state_nx = (job_pat_len == 4'd1) ? WAIT : SEND_PAT;
                            idx_nx   = (job_pat_len == 4'd1) ? SIW'(0) : SIW'(1);
                        end
                    end else begin
                        underrun_set = 1'b1;
                        state_nx     = IDLE;
                        idx_nx       = '0;
                    end
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    armed_clr   = 1'b1;
                    state_nx    = IDLE;
                    idx_nx      = '0;
                end else if (start && !armed) begin
                    latch_job = 1'b1;
                    arm_set   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    // Job context, wait counter, and the registered character stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_str_len  <= '0;
            job_pat_len  <= '0;
            job_send_str <= 1'b0;
            armed        <= 1'b0;
            wait_cnt     <= '0;
            chardata_q   <= '0;
            isstring_q   <= 1'b0;
            ispattern_q  <= 1'b0;
        end else begin
            if (latch_job) begin
                job_str_len  <= str_len;
                job_pat_len  <= pat_len;
                job_send_str <= send_string;
            end
            if (armed_clr)    armed <= 1'b0;
            else if (arm_set) armed <= 1'b1;
            wait_cnt    <= (state == WAIT && !capture) ? wait_cnt + TW'(1) : '0;
            isstring_q  <= (state_nx == SEND_STR);
            ispattern_q <= (state_nx == SEND_PAT);
            case (state_nx)
                SEND_STR: chardata_q <= str_mem[idx_nx];
                SEND_PAT: chardata_q <= pat_mem[idx_nx[PIW-1:0]];
                default:  chardata_q <= '0;
            endcase
        end
    end

    // Result register and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
            res_overrun <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (capture) begin
                res_valid   <= 1'b1;
                res_match   <= sme_match;
                res_index   <= sme_match_index;
                res_timeout <= 1'b0;
            end else if (timeout_hit) begin
                res_valid   <= 1'b1;
                res_match   <= 1'b0;
                res_index   <= '0;
                res_timeout <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if ((capture || timeout_hit) && res_valid && !res_ready) res_overrun <= 1'b1;
            if (underrun_set) underrun <= 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign chardata  = launch_c ? (job_send_str ? str_mem[0] : pat_mem[0]) : chardata_q;
    assign isstring  = launch_c ? job_send_str  : isstring_q;
    assign ispattern = launch_c ? !job_send_str : ispattern_q;

endmodule

// File: tb/tb_sme_job_driver.sv
// Directed bench for sme_job_driver: streaming, armed back-to-back jobs, underrun,
// overrun, timeout and mid-job reset, all against hand-computed values.
module tb_sme_job_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we, cfg_sel;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       send_string, start;
    logic       busy;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       sme_valid, sme_match;
    logic [4:0] sme_match_index;
    logic       res_valid, res_ready, res_match;
    logic [4:0] res_index;
    logic       res_timeout, res_overrun, underrun;

    int checks = 0;
    int errors = 0;

    sme_job_driver dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .str_len(str_len), .pat_len(pat_len), .send_string(send_string), .start(start),
        .busy(busy), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .res_overrun(res_overrun),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_ch [6];
        logic       exp_is [6];
        int n;
        exp_ch = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h62, 8'h63};
        exp_is = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        str_len = '0; pat_len = '0; send_string = 1'b0; start = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0; res_ready = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_stream", {22'd0, chardata, isstring, ispattern}, 0);
        check("rst_res", {27'd0, res_valid, res_match, res_timeout, res_overrun, underrun}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Job 1: "abcd" / "bc"
        write_buf(1'b0, 5'd0, 8'h61); write_buf(1'b0, 5'd1, 8'h62);
        write_buf(1'b0, 5'd2, 8'h63); write_buf(1'b0, 5'd3, 8'h64);
        write_buf(1'b1, 5'd0, 8'h62); write_buf(1'b1, 5'd1, 8'h63);
        str_len = 6'd4; pat_len = 4'd2; send_string = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("j1_char%0d", i), 32'(chardata), 32'(exp_ch[i]));
            check($sformatf("j1_qual%0d", i), {30'd0, isstring, ispattern}, {30'd0, exp_is[i], !exp_is[i]});
            step();
        end
        check("j1_wait_idle", {29'd0, busy, isstring, ispattern}, 32'b100);

        // Arm pattern-only job "d" during WAIT, rewriting the pattern buffer.
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd0; cfg_data = 8'h64;
        pat_len = 4'd1; send_string = 1'b0; start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd1;
        #1;
        check("launch_char", 32'(chardata), 32'h64);
        check("launch_qual", {30'd0, isstring, ispattern}, 32'b01);
        step();
        sme_valid = 1'b0;
        check("j1_result", {25'd0, res_valid, res_match, res_index}, {25'd0, 1'b1, 1'b1, 5'd1});
        check("j2_wait", {27'd0, busy, isstring, ispattern, res_timeout, underrun}, 32'b10000);

        // Arm job 3; job 2 result captured while job 1 result is consumed.
        start = 1'b1;
        step();
        start = 1'b0;
        sme_valid = 1'b1; sme_match = 1'b0; sme_match_index = 5'd3; res_ready = 1'b1;
        step();
        sme_valid = 1'b0; res_ready = 1'b0;
        check("j2_result", {25'd0, res_valid, res_match, res_index}, {25'd0, 1'b1, 1'b0, 5'd3});
        check("j2_no_overrun", 32'(res_overrun), 0);
        check("j3_busy", 32'(busy), 1);

        // Job 3 result unconsumed and nothing armed: overrun and underrun.
        sme_valid = 1'b1; sme_match_index = 5'd7;
        step();
        sme_valid = 1'b0;
        check("j3_index", 32'(res_index), 7);
        check("j3_flags", {30'd0, res_overrun, underrun}, 32'b11);
        check("underrun_idle", {22'd0, busy, chardata, isstring, ispattern}, 0);

        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("consume", 32'(res_valid), 0);

        sme_valid = 1'b1;
        step();
        sme_valid = 1'b0;
        check("valid_in_idle", {30'd0, res_valid, busy}, 0);

        // Timeout: pattern-only job, engine stays silent.
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_send", {23'd0, chardata, ispattern}, {23'd0, 8'h64, 1'b1});
        n = 0;
        while (!res_valid && n < 2000) begin
            step();
            n++;
        end
        check("to_latency", 32'(n), 1024);
        check("to_result", {23'd0, res_valid, res_timeout, res_match, res_index, busy},
              {23'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0});

        // Reset mid-string at idx 2, then restart from str[0].
        str_len = 6'd4; pat_len = 4'd1; send_string = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_reset_char", {23'd0, chardata, isstring}, {23'd0, 8'h63, 1'b1});
        reset = 1'b1;
        #1;
        check("mid_reset", {20'd0, chardata, isstring, busy, res_valid, res_overrun}, 0);
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_char", {23'd0, chardata, isstring}, {23'd0, 8'h61, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
